// File: rtl/lcd_window_stat_if.sv
// Pixel-in / result-out bundle for the 3x3 window statistics block.
interface lcd_window_stat_if;
    logic [7:0]  pix_in;
    logic        pix_valid;
    logic        res_ready;
    logic        res_valid;
    logic [11:0] res_sum;
    logic [7:0]  res_max;
    logic [7:0]  res_min;
    logic [7:0]  res_avg;
    logic        err_partial;
    logic        overflow;
    logic [7:0]  win_cnt;

    // Driver side: pixel source and result consumer.
    modport master (
        output pix_in, pix_valid, res_ready,
        input  res_valid, res_sum, res_max, res_min, res_avg, err_partial, overflow, win_cnt
    );

    // Statistics block side.
    modport slave (
        input  pix_in, pix_valid, res_ready,
        output res_valid, res_sum, res_max, res_min, res_avg, err_partial, overflow, win_cnt
    );
endinterface

// File: rtl/lcd_window_stat.sv
// Collects 9-pixel bursts, computes sum/max/min/avg and queues results in a small FIFO.
module lcd_window_stat #(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input logic              clk,
    input logic              reset,
    lcd_window_stat_if.slave bus
);
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [0:0] {StIdle, StCollect} state_e;

    typedef struct packed {
        logic [11:0] sum;
        logic [7:0]  max;
        logic [7:0]  min;
    } entry_t;

    state_e          state_q, state_d;
    logic [3:0]      idx_q, idx_d;
    logic [11:0]     sum_q, sum_d;
    logic [7:0]      max_q, max_d;
    logic [7:0]      min_q, min_d;
    logic            err_q, err_d;
    logic            ovf_q, ovf_d;
    logic [7:0]      win_cnt_q, win_cnt_d;
    entry_t          mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic   done;
    logic   pop;
    logic   push_ok;
    entry_t merged;
    entry_t head;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Accumulators merged with the current sample; used both mid-window and at completion.
    always_comb begin
        merged.sum = sum_q + {4'd0, bus.pix_in};
        merged.max = (bus.pix_in > max_q) ? bus.pix_in : max_q;
        merged.min = (bus.pix_in < min_q) ? bus.pix_in : min_q;
    end

    // Window FSM next-state: capture, accumulate, complete or abort on a gap.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        sum_d     = sum_q;
        max_d     = max_q;
        min_d     = min_q;
        err_d     = 1'b0;
        win_cnt_d = win_cnt_q;
        done      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.pix_valid) begin
                    sum_d   = {4'd0, bus.pix_in};
                    max_d   = bus.pix_in;
                    min_d   = bus.pix_in;
                    idx_d   = 4'd1;
                    state_d = StCollect;
                end
            end
            StCollect: begin
                if (!bus.pix_valid) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                    idx_d   = '0;
                    sum_d   = '0;
                    max_d   = '0;
                    min_d   = '0;
                end else if (idx_q == 4'd8) begin
                    done      = 1'b1;
                    win_cnt_d = win_cnt_q + 8'd1;
                    state_d   = StIdle;
                    idx_d     = '0;
                    sum_d     = '0;
                    max_d     = '0;
                    min_d     = '0;
                end else begin
                    sum_d = merged.sum;
                    max_d = merged.max;
                    min_d = merged.min;
                    idx_d = idx_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FIFO control: a full FIFO still accepts a push when the head leaves on the same edge.
    always_comb begin
        pop      = (count_q != '0) && bus.res_ready;
        push_ok  = done && ((count_q < CntW'(FIFO_DEPTH)) || pop);
        ovf_d    = ovf_q | (done & ~push_ok);
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CntW'(1);
        end
    end

    // State, accumulator and FIFO registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            sum_q     <= '0;
            max_q     <= '0;
            min_q     <= '0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
            win_cnt_q <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            sum_q     <= sum_d;
            max_q     <= max_d;
            min_q     <= min_d;
            err_q     <= err_d;
            ovf_q     <= ovf_d;
            win_cnt_q <= win_cnt_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            if (push_ok) begin
                mem_q[wr_ptr_q] <= merged;
            end
        end
    end

    // Head outputs are forced to zero while the FIFO is empty.
    always_comb begin
        head            = mem_q[rd_ptr_q];
        bus.res_valid   = (count_q != '0);
        bus.res_sum     = bus.res_valid ? head.sum : '0;
        bus.res_max     = bus.res_valid ? head.max : '0;
        bus.res_min     = bus.res_valid ? head.min : '0;
        bus.res_avg     = bus.res_valid ? 8'(head.sum / 12'd9) : '0;
        bus.err_partial = err_q;
        bus.overflow    = ovf_q;
        bus.win_cnt     = win_cnt_q;
    end
endmodule

// File: tb/tb_lcd_window_stat.sv
// Self-checking bench: directed table, corner-case sequences and randomized traffic vs a model.
module tb_lcd_window_stat;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    lcd_window_stat_if bus ();

    lcd_window_stat #(.FIFO_DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sum;
        int max;
        int min;
    } res_t;

    // Model: pixels of the window in progress and the queued results.
    int   m_win[$];
    res_t m_fifo[$];
    bit   m_err;
    bit   m_ovf;
    int   m_cnt;

    typedef struct {
        bit         pv;
        logic [7:0] pix;
        bit         rdy;
        bit         e_valid;
        int         e_sum;
        int         e_max;
        int         e_min;
        int         e_avg;
        bit         e_err;
        int         e_cnt;
    } vec_t;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_win.delete();
        m_fifo.delete();
        m_err = 1'b0;
        m_ovf = 1'b0;
        m_cnt = 0;
    endtask

    task automatic model_step(input bit pv, input logic [7:0] pix, input bit rdy);
        int   size_before;
        bit   popped;
        bit   complete;
        res_t r;
        size_before = m_fifo.size();
        popped      = (size_before != 0) && rdy;
        complete    = 1'b0;
        m_err       = 1'b0;
        if (pv) begin
            m_win.push_back(int'(pix));
            if (m_win.size() == 9) begin
                complete = 1'b1;
                r.sum = 0;
                r.max = 0;
                r.min = 255;
                foreach (m_win[i]) begin
                    r.sum += m_win[i];
                    if (m_win[i] > r.max) r.max = m_win[i];
                    if (m_win[i] < r.min) r.min = m_win[i];
                end
                m_win.delete();
                m_cnt = (m_cnt + 1) % 256;
            end
        end else if (m_win.size() != 0) begin
            m_err = 1'b1;
            m_win.delete();
        end
        if (popped) void'(m_fifo.pop_front());
        if (complete) begin
            if (size_before < 2 || popped) m_fifo.push_back(r);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic check_model();
        chk("res_valid", 16'(bus.res_valid), 16'(m_fifo.size() != 0));
        if (m_fifo.size() != 0) begin
            chk("res_sum", 16'(bus.res_sum), 16'(m_fifo[0].sum));
            chk("res_max", 16'(bus.res_max), 16'(m_fifo[0].max));
            chk("res_min", 16'(bus.res_min), 16'(m_fifo[0].min));
            chk("res_avg", 16'(bus.res_avg), 16'(m_fifo[0].sum / 9));
        end
        chk("err_partial", 16'(bus.err_partial), 16'(m_err));
        chk("overflow", 16'(bus.overflow), 16'(m_ovf));
        chk("win_cnt", 16'(bus.win_cnt), 16'(m_cnt));
    endtask

    // One clock: drive, let the edge happen, update the model, sample 1 ns later.
    task automatic step(input bit pv, input logic [7:0] pix, input bit rdy);
        bus.pix_valid = pv;
        bus.pix_in    = pix;
        bus.res_ready = rdy;
        @(posedge clk);
        model_step(pv, pix, rdy);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        bus.pix_valid = 1'b0;
        bus.pix_in    = '0;
        bus.res_ready = 1'b0;
        reset = 1'b1;
        #1;
        model_clear();
        chk("rst_valid", 16'(bus.res_valid), 16'd0);
        chk("rst_sum", 16'(bus.res_sum), 16'd0);
        chk("rst_max", 16'(bus.res_max), 16'd0);
        chk("rst_min", 16'(bus.res_min), 16'd0);
        chk("rst_avg", 16'(bus.res_avg), 16'd0);
        chk("rst_err", 16'(bus.err_partial), 16'd0);
        chk("rst_ovf", 16'(bus.overflow), 16'd0);
        chk("rst_cnt", 16'(bus.win_cnt), 16'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic window(input logic [7:0] pix, input bit rdy);
        for (int i = 0; i < 9; i++) step(1'b1, pix, rdy);
    endtask

    vec_t tbl[10];

    initial begin
        bus.pix_valid = 1'b0;
        bus.pix_in    = '0;
        bus.res_ready = 1'b0;
        model_clear();

        for (int i = 0; i < 9; i++) begin
            tbl[i] = '{pv: 1'b1, pix: 8'((i + 1) * 10), rdy: 1'b1, e_valid: 1'b0,
                       e_sum: 0, e_max: 0, e_min: 0, e_avg: 0, e_err: 1'b0, e_cnt: 0};
        end
        tbl[8].e_valid = 1'b1;
        tbl[8].e_sum   = 450;
        tbl[8].e_max   = 90;
        tbl[8].e_min   = 10;
        tbl[8].e_avg   = 50;
        tbl[8].e_cnt   = 1;
        tbl[9] = '{pv: 1'b0, pix: 8'd0, rdy: 1'b1, e_valid: 1'b0,
                   e_sum: 0, e_max: 0, e_min: 0, e_avg: 0, e_err: 1'b0, e_cnt: 1};

        // Single window 10..90, consumed immediately.
        do_reset();
        foreach (tbl[i]) begin
            step(tbl[i].pv, tbl[i].pix, tbl[i].rdy);
            chk("tbl_valid", 16'(bus.res_valid), 16'(tbl[i].e_valid));
            if (tbl[i].e_valid) begin
                chk("tbl_sum", 16'(bus.res_sum), 16'(tbl[i].e_sum));
                chk("tbl_max", 16'(bus.res_max), 16'(tbl[i].e_max));
                chk("tbl_min", 16'(bus.res_min), 16'(tbl[i].e_min));
                chk("tbl_avg", 16'(bus.res_avg), 16'(tbl[i].e_avg));
            end
            chk("tbl_err", 16'(bus.err_partial), 16'(tbl[i].e_err));
            chk("tbl_cnt", 16'(bus.win_cnt), 16'(tbl[i].e_cnt));
        end

        // Partial window, then a full window of 255.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 8'd77, 1'b0);
        step(1'b0, 8'd0, 1'b0);
        chk("partial_err_hi", 16'(bus.err_partial), 16'd1);
        step(1'b0, 8'd0, 1'b0);
        chk("partial_err_lo", 16'(bus.err_partial), 16'd0);
        chk("partial_valid", 16'(bus.res_valid), 16'd0);
        chk("partial_cnt", 16'(bus.win_cnt), 16'd0);
        window(8'd255, 1'b0);
        chk("full255_sum", 16'(bus.res_sum), 16'd2295);
        chk("full255_avg", 16'(bus.res_avg), 16'd255);
        chk("full255_min", 16'(bus.res_min), 16'd255);

        // Back-to-back windows queued with no consumer.
        do_reset();
        window(8'd0, 1'b0);
        window(8'd9, 1'b0);
        chk("b2b_valid", 16'(bus.res_valid), 16'd1);
        chk("b2b_head0", 16'(bus.res_sum), 16'd0);
        step(1'b0, 8'd0, 1'b1);
        chk("b2b_head1", 16'(bus.res_sum), 16'd81);
        chk("b2b_avg1", 16'(bus.res_avg), 16'd9);
        step(1'b0, 8'd0, 1'b1);
        chk("b2b_empty", 16'(bus.res_valid), 16'd0);

        // Third window dropped when full.
        do_reset();
        window(8'd1, 1'b0);
        window(8'd2, 1'b0);
        window(8'd3, 1'b0);
        chk("ovf_set", 16'(bus.overflow), 16'd1);
        chk("ovf_cnt", 16'(bus.win_cnt), 16'd3);
        chk("ovf_head0", 16'(bus.res_sum), 16'd9);
        step(1'b0, 8'd0, 1'b1);
        chk("ovf_head1", 16'(bus.res_sum), 16'd18);
        step(1'b0, 8'd0, 1'b1);
        chk("ovf_empty", 16'(bus.res_valid), 16'd0);

        // Push while full but popping on the same edge is accepted.
        do_reset();
        window(8'd1, 1'b0);
        window(8'd2, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 8'd3, 1'b0);
        step(1'b1, 8'd3, 1'b1);
        chk("popfull_ovf", 16'(bus.overflow), 16'd0);
        chk("popfull_head", 16'(bus.res_sum), 16'd18);
        step(1'b0, 8'd0, 1'b1);
        chk("popfull_next", 16'(bus.res_sum), 16'd27);

        // Reset in the middle of a window.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 8'd200, 1'b0);
        do_reset();
        step(1'b0, 8'd0, 1'b0);
        chk("rstmid_no_err", 16'(bus.err_partial), 16'd0);
        for (int i = 0; i < 9; i++) step(1'b1, 8'(i * 3 + 5), 1'b0);
        chk("rstmid_sum", 16'(bus.res_sum), 16'd153);
        chk("rstmid_max", 16'(bus.res_max), 16'd29);
        chk("rstmid_min", 16'(bus.res_min), 16'd5);
        chk("rstmid_cnt", 16'(bus.win_cnt), 16'd1);

        // Randomized traffic with gaps, back-pressure and rare resets.
        do_reset();
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            step($urandom_range(0, 9) != 0, 8'($urandom), $urandom_range(0, 2) != 0);
        end

        // Enough unbroken windows to wrap the window counter.
        do_reset();
        for (int w = 0; w < 260; w++) begin
            for (int i = 0; i < 9; i++) step(1'b1, 8'($urandom), $urandom_range(0, 1) != 0);
        end
        chk("cnt_wrap", 16'(bus.win_cnt), 16'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
